// File: rtl/speed_estimator.sv
// Measures signed counts per fixed window from a free-running quadrature edge count.
// Saturates the result, keeps a power-of-two moving average and flags stalled windows.
module speed_estimator #(
    parameter int unsigned TICKS_PER_WIN = 50000,
    parameter int unsigned VEL_W         = 16,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned STALL_N       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [31:0]             cnt,
    output logic signed [VEL_W-1:0] vel,
    output logic signed [VEL_W-1:0] vel_avg,
    output logic                    valid,
    output logic                    stall
);
    localparam int unsigned WIN_W   = (TICKS_PER_WIN > 1) ? $clog2(TICKS_PER_WIN) : 1;
    localparam int unsigned AVG_N   = 1 << AVG_LOG2;
    localparam int unsigned PTR_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W   = VEL_W + AVG_LOG2;
    localparam int unsigned STALL_W = 8;

    localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(TICKS_PER_WIN - 1);
    localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(AVG_N - 1);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_N);
    localparam logic signed [31:0]   VEL_MAX   = 32'sh7fff_ffff >>> (32 - VEL_W);
    localparam logic signed [31:0]   VEL_MIN   = ~VEL_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic                            fire_c;

    logic [WIN_W-1:0]                win;
    logic [31:0]                     cnt_last;
    logic [AVG_N-1:0][VEL_W-1:0]     ring;
    logic [PTR_W-1:0]                ptr;
    logic signed [SUM_W-1:0]         sum_q;
    logic [STALL_W-1:0]              stall_cnt;

    logic signed [31:0]              delta_c;
    logic signed [VEL_W-1:0]         vel_sat_c;
    logic signed [SUM_W-1:0]         sum_nxt_c;
    logic signed [VEL_W-1:0]         avg_c;
    logic [STALL_W-1:0]              stall_cnt_nxt_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; dropping en from any state returns to IDLE so every window restarts via PRIME
    always_comb begin
        state_nxt = state;
        fire_c    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   state_nxt = RUN;
                RUN: begin
                    state_nxt = RUN;
                    fire_c    = (win == WIN_LAST);
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Window arithmetic: modulo-2^32 delta, saturation, running sum and stall count
    always_comb begin
        delta_c = $signed(cnt - cnt_last);
        if (delta_c > VEL_MAX) begin
            vel_sat_c = VEL_W'(VEL_MAX);
        end else if (delta_c < VEL_MIN) begin
            vel_sat_c = VEL_W'(VEL_MIN);
        end else begin
            vel_sat_c = VEL_W'(delta_c);
        end

        sum_nxt_c = sum_q + SUM_W'(vel_sat_c) - SUM_W'($signed(ring[ptr]));
        avg_c     = VEL_W'(sum_nxt_c >>> AVG_LOG2);

        if (delta_c != 32'sd0) begin
            stall_cnt_nxt_c = '0;
        end else if (stall_cnt == STALL_MAX) begin
            stall_cnt_nxt_c = stall_cnt;
        end else begin
            stall_cnt_nxt_c = stall_cnt + 1'b1;
        end
    end

    // Datapath registers; everything except the window counter holds while disabled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win       <= '0;
            cnt_last  <= '0;
            ring      <= '0;
            ptr       <= '0;
            sum_q     <= '0;
            stall_cnt <= '0;
            vel       <= '0;
            vel_avg   <= '0;
            valid     <= 1'b0;
            stall     <= 1'b0;
        end else begin
            valid <= fire_c;

            if ((state == RUN) && en) begin
                win <= fire_c ? '0 : win + 1'b1;
            end else begin
                win <= '0;
            end

            if (((state == PRIME) && en) || fire_c) begin
                cnt_last <= cnt;
            end

            if (fire_c) begin
                vel        <= vel_sat_c;
                vel_avg    <= avg_c;
                ring[ptr]  <= vel_sat_c;
                ptr        <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                sum_q      <= sum_nxt_c;
                stall_cnt  <= stall_cnt_nxt_c;
                stall      <= (stall_cnt_nxt_c == STALL_MAX);
            end
        end
    end

endmodule

// File: tb/tb_speed_estimator.sv
// Directed bench for speed_estimator with a 10-cycle window, 4-deep average and stall after 3 windows.
module tb_speed_estimator;
    localparam int unsigned TICKS = 10;
    localparam int unsigned VW    = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [31:0]          cnt;
    logic signed [VW-1:0] vel;
    logic signed [VW-1:0] vel_avg;
    logic                 valid;
    logic                 stall;

    int checks = 0;
    int errors = 0;
    int inc    = 0;

    speed_estimator #(
        .TICKS_PER_WIN (TICKS),
        .VEL_W         (VW),
        .AVG_LOG2      (2),
        .STALL_N       (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cnt     (cnt),
        .vel     (vel),
        .vel_avg (vel_avg),
        .valid   (valid),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    // Advances cnt each cycle until valid is seen; on that cycle switches to the next window's increment and jump
    task automatic wait_window(input int next_inc, input int next_jump, output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (valid) begin
                lat = k;
                inc = next_inc;
                cnt = cnt + 32'(inc + next_jump);
                return;
            end
            cnt = cnt + 32'(inc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        cnt = 32'd0;
        repeat (2) @(negedge clk);
        checks++; if (vel !== 16'sd0) begin errors++; $display("FAIL reset_vel: got %0d expected 0", vel); end
        checks++; if (vel_avg !== 16'sd0) begin errors++; $display("FAIL reset_vel_avg: got %0d expected 0", vel_avg); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d]: got %b expected 0", k, valid); end
        end
    endtask

    task automatic test_ramp();
        int lat;
        int exp_avg [5] = '{2, 5, 7, 10, 10};
        en  = 1'b1;
        inc = 1;
        cnt = cnt + 32'(inc);
        for (int w = 0; w < 5; w++) begin
            wait_window(1, 0, lat);
            // en is seen on the first edge; the first terminal tick is 11 edges later
            checks++; if (lat !== ((w == 0) ? 12 : 10)) begin errors++; $display("FAIL ramp_latency[%0d]: got %0d expected %0d", w, lat, (w == 0) ? 12 : 10); end
            checks++; if (vel !== 16'sd10) begin errors++; $display("FAIL ramp_vel[%0d]: got %0d expected 10", w, vel); end
            checks++; if (vel_avg !== 16'(exp_avg[w])) begin errors++; $display("FAIL ramp_avg[%0d]: got %0d expected %0d", w, vel_avg, exp_avg[w]); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ramp_stall[%0d]: got %b expected 0", w, stall); end
        end
    endtask

    task automatic test_wrap_negative();
        int lat;
        int exp_lat [5]   = '{12, 10, 10, 10, 10};
        int exp_vel [5]   = '{10, -30, -30, -30, -30};
        int exp_avg [5]   = '{10, 0, -10, -20, -30};
        int nxt_inc [5]   = '{-3, -3, -3, -3, 0};
        int nxt_jump [5]  = '{0, 0, 0, 0, 40000};
        bit held_ok = 1'b1;
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (valid !== 1'b0 || vel !== 16'sd10 || vel_avg !== 16'sd10) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL wrap_disabled_hold: got vel %0d avg %0d expected 10 10", vel, vel_avg); end
        // PRIME samples 0x7FFFFFFC; the window ends past the 0x80000000 wrap
        cnt = 32'h7fff_fffb;
        inc = 1;
        en  = 1'b1;
        for (int w = 0; w < 5; w++) begin
            wait_window(nxt_inc[w], nxt_jump[w], lat);
            checks++; if (lat !== exp_lat[w]) begin errors++; $display("FAIL wrap_latency[%0d]: got %0d expected %0d", w, lat, exp_lat[w]); end
            checks++; if (vel !== 16'(exp_vel[w])) begin errors++; $display("FAIL wrap_vel[%0d]: got %0d expected %0d", w, vel, exp_vel[w]); end
            checks++; if (vel_avg !== 16'(exp_avg[w])) begin errors++; $display("FAIL wrap_avg[%0d]: got %0d expected %0d", w, vel_avg, exp_avg[w]); end
        end
    endtask

    task automatic test_saturation();
        int lat;
        int exp_vel [2]  = '{32767, -32768};
        int exp_avg [2]  = '{8169, -16};
        int nxt_jump [2] = '{-40000, 0};
        for (int w = 0; w < 2; w++) begin
            wait_window(0, nxt_jump[w], lat);
            checks++; if (vel !== 16'(exp_vel[w])) begin errors++; $display("FAIL sat_vel[%0d]: got %0d expected %0d", w, vel, exp_vel[w]); end
            checks++; if (vel_avg !== 16'(exp_avg[w])) begin errors++; $display("FAIL sat_avg[%0d]: got %0d expected %0d", w, vel_avg, exp_avg[w]); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_stall[%0d]: got %b expected 0", w, stall); end
        end
    endtask

    task automatic test_stall();
        int lat;
        int exp_vel [5]    = '{0, 0, 0, 0, 1};
        int exp_avg [5]    = '{-8, -1, -8192, 0, 0};
        bit exp_stall [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int nxt_jump [5]   = '{0, 0, 0, 1, 0};
        for (int w = 0; w < 5; w++) begin
            wait_window(0, nxt_jump[w], lat);
            checks++; if (lat !== 10) begin errors++; $display("FAIL stall_latency[%0d]: got %0d expected 10", w, lat); end
            checks++; if (vel !== 16'(exp_vel[w])) begin errors++; $display("FAIL stall_vel[%0d]: got %0d expected %0d", w, vel, exp_vel[w]); end
            checks++; if (vel_avg !== 16'(exp_avg[w])) begin errors++; $display("FAIL stall_avg[%0d]: got %0d expected %0d", w, vel_avg, exp_avg[w]); end
            checks++; if (stall !== exp_stall[w]) begin errors++; $display("FAIL stall_flag[%0d]: got %b expected %b", w, stall, exp_stall[w]); end
        end
    endtask

    task automatic test_enable();
        int lat;
        bit held_ok = 1'b1;
        // Drop en so the edge with window count 5 sees it low
        repeat (4) begin
            @(negedge clk);
            cnt = cnt + 32'(inc);
        end
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cnt = cnt + 32'd7;
            if (valid !== 1'b0 || vel !== 16'sd1 || vel_avg !== 16'sd0 || stall !== 1'b0) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL en_low_hold: got valid %b vel %0d avg %0d stall %b expected 0 1 0 0", valid, vel, vel_avg, stall); end

        @(negedge clk);
        en  = 1'b1;
        inc = 2;
        wait_window(2, 0, lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL reenable_latency: got %0d expected 12", lat); end
        checks++; if (vel !== 16'sd20) begin errors++; $display("FAIL reenable_vel: got %0d expected 20", vel); end
        checks++; if (vel_avg !== 16'sd5) begin errors++; $display("FAIL reenable_avg: got %0d expected 5", vel_avg); end

        // Drop en exactly on the terminal tick: that window is discarded
        repeat (8) begin
            @(negedge clk);
            cnt = cnt + 32'(inc);
        end
        @(negedge clk);
        cnt = cnt + 32'(inc);
        en  = 1'b0;
        held_ok = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (valid !== 1'b0 || vel !== 16'sd20 || vel_avg !== 16'sd5) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL terminal_discard: got valid %b vel %0d avg %0d expected 0 20 5", valid, vel, vel_avg); end
    endtask

    task automatic test_async_reset();
        int lat;
        @(negedge clk);
        en  = 1'b1;
        inc = 1;
        repeat (6) begin
            @(negedge clk);
            cnt = cnt + 32'(inc);
        end
        // Assert reset between clock edges; outputs must clear without a clock edge
        #2;
        rst = 1'b0;
        #1;
        checks++; if (vel !== 16'sd0) begin errors++; $display("FAIL async_rst_vel: got %0d expected 0", vel); end
        checks++; if (vel_avg !== 16'sd0) begin errors++; $display("FAIL async_rst_avg: got %0d expected 0", vel_avg); end
        checks++; if (valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL async_rst_flags: got valid %b stall %b expected 0 0", valid, stall); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cnt = 32'd100;
        wait_window(1, 0, lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL post_rst_latency: got %0d expected 12", lat); end
        checks++; if (vel !== 16'sd10) begin errors++; $display("FAIL post_rst_vel: got %0d expected 10", vel); end
        checks++; if (vel_avg !== 16'sd2) begin errors++; $display("FAIL post_rst_avg: got %0d expected 2", vel_avg); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_wrap_negative();
        test_saturation();
        test_stall();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/speed_estimator.md
SPEED_ESTIMATOR -- requirements
Module: speed_estimator

Interface
REQ-001 Parameter TICKS_PER_WIN, default 50000, meaning clk cycles per measurement window (1 ms at 50 MHz); range 2 or more.
REQ-002 Parameter VEL_W, default 16, meaning signed width of the velocity outputs.
REQ-003 Parameter AVG_LOG2, default 2, meaning the moving-average depth is 2^AVG_LOG2 windows; range 0 to 4.
REQ-004 Parameter STALL_N, default 8, meaning the number of consecutive zero-delta windows that flags a stall; range 1 to 255.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous active-low reset; 0 resets the block immediately.
REQ-007 en  input  1  measurement enable, synchronous to clk.
REQ-008 cnt  input  32  free-running signed edge count from the quadrature decoder, synchronous to clk.
REQ-009 vel  output  VEL_W  signed counts per window for the last window, saturated.
REQ-010 vel_avg  output  VEL_W  signed moving average of the last 2^AVG_LOG2 saturated vel values.
REQ-011 valid  output  1  one-cycle strobe marking that vel, vel_avg and stall were just updated.
REQ-012 stall  output  1  high while STALL_N or more consecutive windows had a zero delta.

Function
REQ-013 The FSM SHALL have three states: IDLE, PRIME and RUN.
REQ-014 IDLE SHALL go to PRIME when en=1 and otherwise hold, with the window counter held at 0.
REQ-015 PRIME SHALL capture cnt into cnt_last on its first en=1 cycle, clear the window counter, produce no valid, and go to RUN.
REQ-016 In RUN, the window counter SHALL count 0 to TICKS_PER_WIN-1 and wrap to 0.
REQ-017 On the edge where the window counter equals TICKS_PER_WIN-1 in RUN, delta SHALL equal cnt - cnt_last modulo 2^32, read as signed 32-bit, so wrap of cnt at 0x7FFFFFFF/0x80000000 gives the correct small delta.
REQ-018 On that same edge, cnt_last SHALL load the current cnt.
REQ-019 On that same edge, vel SHALL load delta saturated to [-(2^(VEL_W-1)), 2^(VEL_W-1)-1].
REQ-020 On that same edge, valid SHALL go high for exactly the next cycle; vel, vel_avg and stall update on the same edge as valid rises.
REQ-021 The average SHALL use a ring buffer of 2^AVG_LOG2 saturated vel values and a running sum of width VEL_W+AVG_LOG2.
REQ-022 Each window, the sum SHALL update as sum + new - oldest, the oldest slot is replaced by new, and vel_avg = new sum arithmetic-shifted right by AVG_LOG2 (floor toward minus infinity).
REQ-023 Ring slots SHALL be zero after reset, so the first 2^AVG_LOG2-1 averages include zeros; with AVG_LOG2=0, vel_avg equals vel.
REQ-024 The stall counter SHALL saturate at STALL_N, increment on each window with delta=0, and clear on a nonzero delta.
REQ-025 stall SHALL be high when the stall counter equals STALL_N, and SHALL fall on the same edge that clears the counter.
REQ-026 en=0 in any state SHALL move the FSM to IDLE on the next edge, clear the window counter, suppress valid, and hold vel, vel_avg, stall, ring and sum.
REQ-027 Re-enabling SHALL always pass through PRIME, so no window straddles a disabled interval.
REQ-028 If en falls on the terminal-tick edge, that window SHALL be discarded, with no valid and no update.
REQ-029 delta SHALL use cnt as sampled at the terminal tick only; cnt changing on that edge is seen at the next window.

Reset
REQ-030 While rst=0: state=IDLE; window counter, cnt_last, sum, all ring slots and the stall counter are 0; vel=0, vel_avg=0, valid=0, stall=0.
REQ-031 Reset SHALL take effect asynchronously and be released synchronously; mid-window assertion discards all partial-window state.
REQ-032 The first valid after reset release SHALL occur no earlier than TICKS_PER_WIN+1 cycles after en is first seen high.

Verification (TICKS_PER_WIN=10, VEL_W=16, AVG_LOG2=2, STALL_N=3)
REQ-033 Ramp: reset, then en=1 with cnt += 1 per cycle -> first valid after 11 cycles with vel=10, vel_avg=2; then vel_avg = 5, 7, 10, and stays 10 after that.
REQ-034 Negative and wrap: cnt starts at 0x7FFFFFFC and gets +1 per cycle for 10 cycles -> vel=+10 across the 0x7FFFFFFF->0x80000000 wrap; then -3 per cycle -> vel=-30 and vel_avg follows floor rounding (-30+10+10+10)/4 = 0.
REQ-035 Saturation: cnt jumps +40000 within one window -> vel=32767; a jump of -40000 -> vel=-32768.
REQ-036 Stall: cnt held constant for 3 windows -> stall=1 with the 3rd valid; one window with delta=1 -> stall=0 with that valid.
REQ-037 Enable and reset: en=0 at tick 5 of a window -> no valid and outputs held; en=1 -> first valid 11 cycles later; rst=0 mid-window -> all outputs 0 immediately, without waiting for a clk edge.
